trim_sequencer: RTL and testbench

- Time-multiplexes one shared unsigned pipelined multiplier across the four per-button magnitude channels. Each strobe triggers one gain-compensation pass.
- Captures a magnitude/gain snapshot on strobe and issues the four operand pairs on consecutive cycles. It then collects, rounds and saturates the products and publishes all four trimmed magnitudes at once with a toggle.
- Sits between the magnitude computation and the position calculation. It replaces the four-multiplier trim datapath in resource-constrained builds.

---
 rtl/trim_sequencer.sv | 152 +++++++++++++++
 tb/tb_trim_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trim_sequencer.sv
// Gain-compensation sequencer: shares one pipelined multiplier across four magnitude channels
// and publishes the four rounded, saturated products together with a toggle.
module trim_sequencer #(
    parameter int unsigned MAG_WIDTH    = 26,
    parameter int unsigned GAIN_WIDTH   = 27,
    parameter int unsigned MULT_LATENCY = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            strobe,
    input  logic [4*MAG_WIDTH-1:0]          magnitudes,
    input  logic [4*GAIN_WIDTH-1:0]         gains,
    output logic [MAG_WIDTH-1:0]            mulA,
    output logic [GAIN_WIDTH-1:0]           mulB,
    input  logic [MAG_WIDTH+GAIN_WIDTH-1:0] mulP,
    output logic                            busy,
    output logic [7:0]                      overrunCount,
    output logic                            trimmedToggle,
    output logic [4*MAG_WIDTH-1:0]          trimmed
);

    localparam int unsigned PW = MAG_WIDTH + GAIN_WIDTH;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [MAG_WIDTH-1:0]    mag_snap_q  [4];
    logic [GAIN_WIDTH-1:0]   gain_snap_q [4];
    logic [MULT_LATENCY-1:0] trk_valid_q;
    logic [1:0]              trk_ch_q    [MULT_LATENCY];
    logic [MAG_WIDTH-1:0]    hold_q      [3];
    logic [4*MAG_WIDTH-1:0]  trimmed_q;
    logic                    toggle_q;
    logic [7:0]              overrun_q;

    logic                    issue_valid;
    logic                    snap_load;
    logic                    overrun_inc;
    logic                    capture_valid;
    logic [1:0]              capture_ch;
    logic                    publish;
    logic [MAG_WIDTH:0]      q_sum;
    logic [MAG_WIDTH-1:0]    rounded;
    logic                    unused_mulp_lsbs;

    assign capture_valid    = trk_valid_q[MULT_LATENCY-1];
    assign capture_ch       = trk_ch_q[MULT_LATENCY-1];
    assign publish          = capture_valid && (capture_ch == 2'd3);
    assign unused_mulp_lsbs = ^mulP[GAIN_WIDTH-3:0];

    // Round half up on the fractional MSB; saturate on product overflow or increment carry.
    always_comb begin
        q_sum = {1'b0, mulP[GAIN_WIDTH-1 +: MAG_WIDTH]}
              + {{MAG_WIDTH{1'b0}}, mulP[GAIN_WIDTH-2]};
        if (mulP[PW-1] || q_sum[MAG_WIDTH]) begin
            rounded = '1;
        end else begin
            rounded = q_sum[MAG_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        issue_valid = 1'b0;
        snap_load   = 1'b0;
        mulA        = '0;
        mulB        = '0;
        overrun_inc = strobe && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    snap_load = 1'b1;
                    idx_d     = 2'd0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                mulA        = mag_snap_q[idx_q];
                mulB        = gain_snap_q[idx_q];
                issue_valid = 1'b1;
                idx_d       = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (publish) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            trk_valid_q <= '0;
            for (int i = 0; i < int'(MULT_LATENCY); i++) begin
                trk_ch_q[i] <= 2'd0;
            end
            for (int c = 0; c < 4; c++) begin
                mag_snap_q[c]  <= '0;
                gain_snap_q[c] <= '0;
            end
            for (int c = 0; c < 3; c++) begin
                hold_q[c] <= '0;
            end
            trimmed_q <= '0;
            toggle_q  <= 1'b0;
            overrun_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            // Tracking pipe mirrors the multiplier latency so each product finds its channel.
            trk_valid_q <= {trk_valid_q[MULT_LATENCY-2:0], issue_valid};
            trk_ch_q[0] <= idx_q;
            for (int i = 1; i < int'(MULT_LATENCY); i++) begin
                trk_ch_q[i] <= trk_ch_q[i-1];
            end
            if (snap_load) begin
                for (int c = 0; c < 4; c++) begin
                    mag_snap_q[c]  <= magnitudes[c*MAG_WIDTH +: MAG_WIDTH];
                    gain_snap_q[c] <= gains[c*GAIN_WIDTH +: GAIN_WIDTH];
                end
            end
            if (capture_valid && !publish) begin
                for (int c = 0; c < 3; c++) begin
                    if (capture_ch == 2'(c)) begin
                        hold_q[c] <= rounded;
                    end
                end
            end
            if (publish) begin
                trimmed_q <= {rounded, hold_q[2], hold_q[1], hold_q[0]};
                toggle_q  <= ~toggle_q;
            end
            if (overrun_inc && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    assign busy          = (state_q != StIdle);
    assign overrunCount  = overrun_q;
    assign trimmedToggle = toggle_q;
    assign trimmed       = trimmed_q;

endmodule

// File: tb/tb_trim_sequencer.sv
// Scoreboard bench for trim_sequencer: a pipelined multiplier model feeds the DUT, a reference
// model predicts accepted passes and their results, and a monitor checks each publish.
module tb_trim_sequencer;

    localparam int MW = 26;
    localparam int GW = 27;
    localparam int L  = 6;
    localparam int PW = MW + GW;

    logic              clk;
    logic              rst;
    logic              strobe;
    logic [4*MW-1:0]   magnitudes;
    logic [4*GW-1:0]   gains;
    logic [MW-1:0]     mulA;
    logic [GW-1:0]     mulB;
    logic [PW-1:0]     mulP;
    logic              busy;
    logic [7:0]        overrunCount;
    logic              trimmedToggle;
    logic [4*MW-1:0]   trimmed;

    trim_sequencer #(
        .MAG_WIDTH   (MW),
        .GAIN_WIDTH  (GW),
        .MULT_LATENCY(L)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .strobe       (strobe),
        .magnitudes   (magnitudes),
        .gains        (gains),
        .mulA         (mulA),
        .mulB         (mulB),
        .mulP         (mulP),
        .busy         (busy),
        .overrunCount (overrunCount),
        .trimmedToggle(trimmedToggle),
        .trimmed      (trimmed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // Multiplier model: operands sampled at edge n, product valid before edge n+L.
    logic [PW-1:0] pipe [L];
    initial for (int i = 0; i < L; i++) pipe[i] = '0;
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= PW'(mulA) * PW'(mulB);
    end
    assign mulP = pipe[L-1];

    typedef struct {
        logic [4*MW-1:0] val;
        int              pub_edge;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   have_pass = 0;
    int   la = 0;
    int   dropped = 0;

    task automatic check(input string name, input logic [4*MW-1:0] act, input logic [4*MW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    function automatic logic [MW-1:0] ref_trim(input logic [MW-1:0] m, input logic [GW-1:0] g);
        logic [63:0] p;
        logic [63:0] r;
        p = 64'(m) * 64'(g);
        r = (p + (64'd1 << (GW - 2))) >> (GW - 1);
        if (r >= (64'd1 << MW)) return '1;
        return r[MW-1:0];
    endfunction

    function automatic logic [MW-1:0] rand_mag();
        case ($urandom_range(0, 3))
            0: return '1;
            1: return MW'($urandom_range(0, 5000));
            default: return MW'($urandom);
        endcase
    endfunction

    function automatic logic [GW-1:0] rand_gain();
        case ($urandom_range(0, 3))
            0: return '1;
            1: return 27'h4000000;
            default: return GW'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        for (int c = 0; c < 4; c++) begin
            magnitudes[c*MW +: MW] = rand_mag();
            gains[c*GW +: GW]      = rand_gain();
        end
    endtask

    // Drives one strobe cycle; the reference model decides acceptance from the pass period alone.
    task automatic strobe_pass(input logic [4*MW-1:0] m, input logic [4*GW-1:0] g);
        int   e;
        exp_t x;
        e          = edge_cnt + 1;
        magnitudes = m;
        gains      = g;
        strobe     = 1'b1;
        if (!have_pass || e >= la + 5 + L) begin
            have_pass = 1;
            la        = e;
            for (int c = 0; c < 4; c++) x.val[c*MW +: MW] = ref_trim(m[c*MW +: MW], g[c*GW +: GW]);
            x.pub_edge = e + 4 + L;
            exp_q.push_back(x);
        end else begin
            dropped++;
        end
        @(posedge clk);
        #1;
        strobe = 1'b0;
        scramble_inputs();
    endtask

    task automatic strobe_random();
        logic [4*MW-1:0] m;
        logic [4*GW-1:0] g;
        for (int c = 0; c < 4; c++) begin
            m[c*MW +: MW] = rand_mag();
            g[c*GW +: GW] = rand_gain();
        end
        strobe_pass(m, g);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d passes never published, expected 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    task automatic pulse_reset();
        rst       = 1'b1;
        have_pass = 0;
        dropped   = 0;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
    endtask

    // Monitor: busy against the model every cycle; each toggle pops one expected publish.
    logic prev_tog = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_tog = 1'b0;
            end else begin
                check("busy", 104'(busy),
                      104'(have_pass && edge_cnt >= la && edge_cnt < la + 4 + L));
                if (trimmedToggle !== prev_tog) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_publish", 104'(trimmedToggle), 104'(prev_tog));
                    end else begin
                        exp_t x;
                        x = exp_q.pop_front();
                        check("trimmed", trimmed, x.val);
                        check("publish_edge", 104'(edge_cnt), 104'(x.pub_edge));
                    end
                    prev_tog = trimmedToggle;
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        strobe     = 1'b0;
        magnitudes = '0;
        gains      = '0;
        idle(3);
        rst = 1'b0;
        idle(20);
        check("reset_trimmed", trimmed, '0);
        check("reset_toggle", 104'(trimmedToggle), 104'(0));
        check("reset_overrun", 104'(overrunCount), 104'(0));
        check("reset_mulA", 104'(mulA), 104'(0));
        check("reset_mulB", 104'(mulB), 104'(0));

        // Unity gain, with the operand issue order observed directly.
        strobe_pass({26'd4000, 26'd3000, 26'd2000, 26'd1000}, {4{27'h4000000}});
        for (int k = 0; k < 4; k++) begin
            check("issue_mulA", 104'(mulA), 104'(1000 * (k + 1)));
            check("issue_mulB", 104'(mulB), 104'(27'h4000000));
            idle(1);
        end
        check("drain_mulA", 104'(mulA), 104'(0));
        wait_drain();
        check("unity_result", trimmed, {26'd4000, 26'd3000, 26'd2000, 26'd1000});

        // Rounding and saturation in one pass.
        strobe_pass({26'h3FFFFFF, 26'd7, 26'd1000, 26'd1001},
                    {27'h7FFFFFF, 27'h5555555, 27'h2000000, 27'h2000000});
        wait_drain();
        check("round_sat_result", trimmed, {26'h3FFFFFF, 26'd9, 26'd500, 26'd501});

        // Overrun: strobes at E0, E3, E10, E11; passes at E0 and E11.
        strobe_random();
        idle(2);
        strobe_random();
        idle(6);
        strobe_random();
        strobe_random();
        wait_drain();
        check("overrun_two", 104'(overrunCount), 104'(2));

        // Reset mid-pass: the in-flight pass must never publish.
        strobe_random();
        idle(5);
        pulse_reset();
        idle(30);
        check("midreset_toggle", 104'(trimmedToggle), 104'(0));
        check("midreset_trimmed", trimmed, '0);
        check("midreset_overrun", 104'(overrunCount), 104'(0));
        strobe_random();
        wait_drain();

        // Randomized passes with random gaps, some strobes dropped.
        for (int i = 0; i < 60; i++) begin
            strobe_random();
            idle($urandom_range(0, 12));
        end
        wait_drain();
        check("overrun_random", 104'(overrunCount), 104'(dropped > 255 ? 255 : dropped));

        // Continuous strobing drives the overrun counter into saturation.
        for (int i = 0; i < 350; i++) strobe_random();
        wait_drain();
        check("overrun_saturate", 104'(overrunCount), 104'(255));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
